// File: rtl/serial_alu_param_pkg.sv
// Shared opcode and FSM state definitions for the bit-serial ALU.
package serial_alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_PASSA = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only ADD/SUB produce meaningful carry/overflow flags.
    function automatic logic is_arith(logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_param_if.sv
// Request/response bundle between the operand source and the serial ALU.
interface serial_alu_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       opcode;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             negative;

    modport master (
        output start, A, B, opcode,
        input  ready, busy, done, result, zero, carry, overflow, negative
    );

    modport slave (
        input  start, A, B, opcode,
        output ready, busy, done, result, zero, carry, overflow, negative
    );
endinterface

// File: rtl/serial_alu_param_slice.sv
// Combinational 1-bit ALU slice; SUB inverts B here, the +1 comes in as cin.
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] opcode,
    output logic       r,
    output logic       cout
);
    logic bx;

    always_comb begin
        bx   = (opcode == OP_SUB) ? ~b : b;
        r    = a;
        cout = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                r    = a ^ bx ^ cin;
                cout = (a & bx) | (cin & (a ^ bx));
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = a;
        endcase
    end
endmodule

// File: rtl/serial_alu_param.sv
// Bit-serial ALU: latches operands on start, processes one bit per clock LSB-first,
// publishes result and flags on the completion edge.
module serial_alu_param
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    serial_alu_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [2:0]       op_q;
    logic             cy_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, carry_q, ovf_q, neg_q;
    logic             bit_r, bit_cout;
    logic             last, take;
    logic [WIDTH-1:0] final_res;

    assign last      = (cnt == CNT_W'(WIDTH - 1));
    assign take      = (state != ST_RUN) && bus.start;
    // a_sh doubles as the result accumulator: result bits enter at the MSB.
    assign final_res = {bit_r, a_sh[WIDTH-1:1]};

    serial_alu_slice u_slice (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .cin    (cy_q),
        .opcode (op_q),
        .r      (bit_r),
        .cout   (bit_cout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.start) state_nx = ST_RUN;
            ST_RUN:  if (last)      state_nx = ST_DONE;
            ST_DONE: state_nx = bus.start ? ST_RUN : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            op_q     <= OP_ADD;
            cy_q     <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
        end else if (take) begin
            a_sh <= bus.A;
            b_sh <= bus.B;
            op_q <= bus.opcode;
            cy_q <= (bus.opcode == OP_SUB);
            cnt  <= '0;
        end else if (state == ST_RUN) begin
            a_sh <= final_res;
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            cy_q <= bit_cout;
            cnt  <= cnt + 1'b1;
            if (last) begin
                // cy_q here is the carry into the MSB, bit_cout the carry out.
                result_q <= final_res;
                zero_q   <= ~|final_res;
                neg_q    <= bit_r;
                carry_q  <= is_arith(op_q) & bit_cout;
                ovf_q    <= is_arith(op_q) & (cy_q ^ bit_cout);
            end
        end
    end

    assign bus.ready    = (state != ST_RUN);
    assign bus.busy     = (state == ST_RUN);
    assign bus.done     = (state == ST_DONE);
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.negative = neg_q;
endmodule

// File: doc/serial_alu_param.md
Name: serial_alu_param

Overview:
- Parametrised, true bit-serial successor to the 4-bit serial ALU.
- Operands and opcode are latched on a start handshake, then processed LSB-first at one bit per clock through a single 1-bit datapath slice.
- The registered result and flags are published on completion and held until the next operation completes.
- Sits between the operand register file and the status/writeback logic; trades latency for area at arbitrary widths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when ready=1
- A  input  WIDTH  operand A, sampled with start
- B  input  WIDTH  operand B, sampled with start
- opcode  input  3  operation select, sampled with start
- ready  output  1  high when able to accept start (IDLE or DONE)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result and flags updated this cycle
- result  output  WIDTH  last completed result
- zero  output  1  result==0
- carry  output  1  ADD carry-out; SUB not-borrow; 0 for logic ops
- overflow  output  1  signed overflow for ADD/SUB; 0 otherwise
- negative  output  1  result[WIDTH-1]

Behaviour:
- Reset (reset=0, any time, including mid-RUN):
  - State goes to IDLE; counter and shift registers clear.
  - result, zero, carry, overflow, negative, done and busy all 0; ready=1.
  - An in-flight operation is discarded and no done pulse follows.
- Opcodes:
  - 000 ADD
  - 001 SUB (A + ~B + 1)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 PASSA
  - 110, 111 reserved, execute as PASSA.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE to RUN: on start=1. A, B and opcode are latched into shift registers. Counter=0. Carry register = 1 for SUB, else 0.
  - DONE to IDLE: start=0. DONE lasts exactly one cycle.
  - RUN: each edge computes bit[cnt] from the LSBs of the A/B shift registers and the carry register. Both shift registers shift right and the result bit shifts in at the MSB. Counter increments.
  - RUN to DONE: on the edge processing bit WIDTH-1. On that same edge, result and all flags are written from the final values.
- Latency: done is high in the cycle after the WIDTH-th edge following the edge that sampled start. Throughput is one operation per WIDTH+1 cycles with back-to-back starts.
- start while busy=1 is ignored and not queued. Changes to A/B/opcode during RUN have no effect.
- result and flags hold their previous values throughout RUN, changing only on the completion edge.
- Flag rules:
  - overflow = carry into MSB XOR carry out of MSB, for ADD/SUB only.
  - carry is the final carry register for ADD/SUB, else 0.
  - zero is computed on the full WIDTH-bit result.
- Outputs:
  - ready = (state != RUN); busy = (state == RUN); done = (state == DONE).
  - All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package serial_alu_pkg:
  - opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_PASSA.
  - State encoding: ST_IDLE, ST_RUN, ST_DONE.
- One sub-module, serial_alu_slice: combinational 1-bit slice.
  - Inputs: a, b, cin, opcode.
  - Outputs: r, cout.
  - B inversion for SUB happens inside the slice.
- The top level holds the FSM, counter, shift registers and flag registers.

Test Plan:
- WIDTH=8, ADD A=8'hFF B=8'h01 -> done 8 edges after start; result=8'h00, zero=1, carry=1, overflow=0, negative=0.
- ADD A=8'h7F B=8'h01 -> result=8'h80, overflow=1, negative=1, carry=0, zero=0.
- SUB A=8'h05 B=8'h07 -> result=8'hFE, carry=0, negative=1, overflow=0; then SUB 8'h07-8'h05 back-to-back (start during done) -> result=8'h02, carry=1, next done exactly 9 cycles after the first.
- XOR A=8'hA5 B=8'hA5 -> result=8'h00, zero=1, carry=0; start pulsed again mid-RUN with A=8'hFF -> ignored, only one done, result unaffected.
- Reset asserted at bit 4 of ADD 8'h10+8'h20 -> all outputs 0 immediately (async); after release ready=1, no done pulse; a new OR 8'hF0|8'h0F gives result=8'hFF.
- Parameter sweep WIDTH=2, 5, 32: random ADD/SUB/AND/OR/XOR/reserved compared against a reference model; latency=WIDTH edges in every case.
